// File: rtl/fir_channel_arbiter.sv
// Round-robin packet arbiter that shares one fir_top datapath between N_CH
// Avalon-ST sources, holding new grants until fir_top returns the matching eop.
module fir_channel_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int N_CH           = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_CH-1:0]            ch_valid,
  output logic [N_CH-1:0]            ch_ready,
  input  logic [N_CH-1:0]            ch_startofpacket,
  input  logic [N_CH-1:0]            ch_endofpacket,
  input  logic [N_CH*DATA_WIDTH-1:0] ch_data,
  output logic                       fir_in_valid,
  input  logic                       fir_in_ready,
  output logic                       fir_in_startofpacket,
  output logic                       fir_in_endofpacket,
  output logic [DATA_WIDTH-1:0]      fir_in_data,
  input  logic                       fir_out_valid,
  input  logic                       fir_out_endofpacket,
  output logic [$clog2(N_CH)-1:0]    result_channel,
  output logic                       result_channel_valid,
  output logic                       timeout_err,
  output logic [15:0]                stray_count
);

  localparam int CH_W = $clog2(N_CH);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FORWARD,
    S_WAIT_RESULT
  } state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] last_grant_q, last_grant_d;
  logic [CH_W-1:0] result_channel_q, result_channel_d;
  logic            result_channel_valid_q, result_channel_valid_d;
  logic            timeout_err_q, timeout_err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [15:0]     stray_count_q, stray_count_d;
  // Low while reset_n is asserted so IDLE cannot drain stray beats during reset.
  logic            active_q, active_d;

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] drain;
  logic            win_found;
  logic [CH_W-1:0] winner;
  int              scan_idx;
  logic [16:0]     stray_sum;
  logic            fwd_xfer;

  always_comb begin : arbitrate
    req       = ch_valid & ch_startofpacket;
    win_found = 1'b0;
    winner    = '0;
    scan_idx  = 0;
    for (int k = 1; k <= N_CH; k++) begin
      scan_idx = (int'(last_grant_q) + k) % N_CH;
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        winner    = CH_W'(scan_idx);
      end
    end
  end

  always_comb begin : stray_drain
    drain = '0;
    if (state_q == S_IDLE && active_q) begin
      drain = ch_valid & ~ch_startofpacket;
    end
    stray_sum = {1'b0, stray_count_q};
    for (int i = 0; i < N_CH; i++) begin
      stray_sum = stray_sum + 17'(drain[i]);
    end
  end

  always_comb begin : datapath_mux
    ch_ready             = drain;
    fir_in_valid         = 1'b0;
    fir_in_startofpacket = 1'b0;
    fir_in_endofpacket   = 1'b0;
    fir_in_data          = '0;
    fwd_xfer             = 1'b0;
    if (state_q == S_FORWARD) begin
      ch_ready[grant_q]    = fir_in_ready;
      fir_in_valid         = ch_valid[grant_q];
      fir_in_startofpacket = ch_startofpacket[grant_q];
      fir_in_endofpacket   = ch_endofpacket[grant_q];
      fir_in_data          = ch_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      fwd_xfer             = ch_valid[grant_q] & fir_in_ready;
    end
  end

  always_comb begin : next_state
    state_d                = state_q;
    grant_d                = grant_q;
    last_grant_d           = last_grant_q;
    result_channel_d       = result_channel_q;
    result_channel_valid_d = result_channel_valid_q;
    timeout_err_d          = 1'b0;
    to_cnt_d               = to_cnt_q;
    active_d               = 1'b1;
    stray_count_d          = (stray_sum > 17'h0FFFF) ? 16'hFFFF : stray_sum[15:0];

    case (state_q)
      S_IDLE: begin
        if (active_q && win_found) begin
          state_d                = S_FORWARD;
          grant_d                = winner;
          result_channel_d       = winner;
          result_channel_valid_d = 1'b1;
          to_cnt_d               = '0;
        end
      end
      S_FORWARD: begin
        if (fwd_xfer && ch_endofpacket[grant_q]) begin
          state_d = S_WAIT_RESULT;
        end
      end
      S_WAIT_RESULT: begin
        // A returning eop takes precedence over a coincident timeout.
        if (fir_out_valid && fir_out_endofpacket) begin
          state_d                = S_IDLE;
          last_grant_d           = grant_q;
          result_channel_valid_d = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d                = S_IDLE;
          last_grant_d           = grant_q;
          result_channel_valid_d = 1'b0;
          timeout_err_d          = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q                <= S_IDLE;
      grant_q                <= '0;
      last_grant_q           <= CH_W'(N_CH - 1);
      result_channel_q       <= '0;
      result_channel_valid_q <= 1'b0;
      timeout_err_q          <= 1'b0;
      to_cnt_q               <= '0;
      stray_count_q          <= '0;
      active_q               <= 1'b0;
    end else begin
      state_q                <= state_d;
      grant_q                <= grant_d;
      last_grant_q           <= last_grant_d;
      result_channel_q       <= result_channel_d;
      result_channel_valid_q <= result_channel_valid_d;
      timeout_err_q          <= timeout_err_d;
      to_cnt_q               <= to_cnt_d;
      stray_count_q          <= stray_count_d;
      active_q               <= active_d;
    end
  end

  assign result_channel       = result_channel_q;
  assign result_channel_valid = result_channel_valid_q;
  assign timeout_err          = timeout_err_q;
  assign stray_count          = stray_count_q;

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// Self-checking bench for fir_channel_arbiter: per-channel packet queues drive the
// sources, accepted fir_in beats are captured and compared with a packet-level model.
module tb_fir_channel_arbiter;

  localparam int DW = 16;
  localparam int NC = 4;

  logic            clk;
  logic            reset_n;
  logic [NC-1:0]   ch_valid;
  logic [NC-1:0]   ch_ready;
  logic [NC-1:0]   ch_startofpacket;
  logic [NC-1:0]   ch_endofpacket;
  logic [NC*DW-1:0] ch_data;
  logic            fir_in_valid;
  logic            fir_in_ready;
  logic            fir_in_startofpacket;
  logic            fir_in_endofpacket;
  logic [DW-1:0]   fir_in_data;
  logic            fir_out_valid;
  logic            fir_out_endofpacket;
  logic [1:0]      result_channel;
  logic            result_channel_valid;
  logic            timeout_err;
  logic [15:0]     stray_count;

  fir_channel_arbiter #(.DATA_WIDTH(DW), .N_CH(NC), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_startofpacket(ch_startofpacket), .ch_endofpacket(ch_endofpacket),
    .ch_data(ch_data),
    .fir_in_valid(fir_in_valid), .fir_in_ready(fir_in_ready),
    .fir_in_startofpacket(fir_in_startofpacket), .fir_in_endofpacket(fir_in_endofpacket),
    .fir_in_data(fir_in_data),
    .fir_out_valid(fir_out_valid), .fir_out_endofpacket(fir_out_endofpacket),
    .result_channel(result_channel), .result_channel_valid(result_channel_valid),
    .timeout_err(timeout_err), .stray_count(stray_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; logic sop; logic eop; } beat_t;
  typedef struct { logic [15:0] d; logic sop; logic eop; int ch; int cyc; } cap_t;

  beat_t chq[NC][$];
  beat_t expq[NC][$];
  cap_t  cap[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;     // 0: always ready, 1: random, 2: 1,0,0,1 pattern
  bit rand_valid = 0;
  bit rand_delay = 0;
  int fir_delay = 3;    // cycles from fir_in eop to fir_out eop; -1 = never
  int ret_cnt = -1;
  int to_pulses = 0;
  int to_cyc = -1;

  logic [NC-1:0] s_ready;
  logic          s_fv, s_rdy, s_rcv;
  logic [1:0]    s_rc;
  logic [15:0]   s_stray;

  function automatic beat_t mk(logic [15:0] d, logic s, logic e);
    beat_t b;
    b.d = d; b.sop = s; b.eop = e;
    return b;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NC; i++) if (chq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_pkt(int ch, int len, logic [15:0] base);
    for (int b = 0; b < len; b++)
      chq[ch].push_back(mk(base + 16'(b), b == 0, b == len - 1));
  endtask

  task automatic clear_inputs();
    ch_valid = '0; ch_startofpacket = '0; ch_endofpacket = '0; ch_data = '0;
    fir_in_ready = 1'b0; fir_out_valid = 1'b0; fir_out_endofpacket = 1'b0;
  endtask

  // One clock: drive at negedge, sample 1 time unit later, consume at posedge.
  task automatic step();
    logic [NC-1:0] hs;
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      if (chq[i].size() > 0 && (!rand_valid || ($urandom % 4) != 0)) begin
        ch_valid[i] = 1'b1;
        ch_startofpacket[i] = chq[i][0].sop;
        ch_endofpacket[i] = chq[i][0].eop;
        ch_data[i*DW +: DW] = chq[i][0].d;
      end else begin
        ch_valid[i] = 1'b0; ch_startofpacket[i] = 1'b0; ch_endofpacket[i] = 1'b0;
        ch_data[i*DW +: DW] = '0;
      end
    end
    case (rdy_mode)
      0: fir_in_ready = 1'b1;
      1: fir_in_ready = (($urandom % 3) != 0);
      default: fir_in_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    endcase
    if (ret_cnt == 0) begin
      fir_out_valid = 1'b1; fir_out_endofpacket = 1'b1; ret_cnt = -1;
    end else begin
      fir_out_valid = 1'b0; fir_out_endofpacket = 1'b0;
      if (ret_cnt > 0) ret_cnt--;
    end
    #1;
    s_ready = ch_ready; s_fv = fir_in_valid; s_rdy = fir_in_ready;
    s_rcv = result_channel_valid; s_rc = result_channel; s_stray = stray_count;
    if (timeout_err) begin to_pulses++; to_cyc = cyc; end
    if (fir_in_valid && fir_in_ready) begin
      cap_t c;
      c.d = fir_in_data; c.sop = fir_in_startofpacket; c.eop = fir_in_endofpacket;
      c.ch = int'(result_channel); c.cyc = cyc;
      cap.push_back(c);
      if (fir_in_endofpacket) ret_cnt = rand_delay ? int'($urandom_range(0, 6)) : fir_delay;
    end
    hs = ch_valid & ch_ready;
    @(posedge clk);
    for (int i = 0; i < NC; i++) if (hs[i]) void'(chq[i].pop_front());
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    for (int i = 0; i < NC; i++) chq[i].delete();
    ret_cnt = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(); step();
    cap.delete();
    to_pulses = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    ch_valid = 4'b1000;
    @(posedge clk); #1;
    n_vec++; if (ch_ready !== 4'b0) begin n_err++; $display("FAIL reset_ch_ready: got %b want 0000", ch_ready); end
    n_vec++; if ({fir_in_valid, fir_in_startofpacket, fir_in_endofpacket} !== 3'b0) begin n_err++; $display("FAIL reset_fir_in_ctl: got %b want 000", {fir_in_valid, fir_in_startofpacket, fir_in_endofpacket}); end
    n_vec++; if (fir_in_data !== 16'h0) begin n_err++; $display("FAIL reset_fir_in_data: got %h want 0000", fir_in_data); end
    n_vec++; if ({result_channel_valid, result_channel, timeout_err} !== 4'b0) begin n_err++; $display("FAIL reset_result: got %b want 0000", {result_channel_valid, result_channel, timeout_err}); end
    n_vec++; if (stray_count !== 16'h0) begin n_err++; $display("FAIL reset_stray_count: got %0d want 0", stray_count); end
    do_reset();
  endtask

  task automatic test_single();
    int start;
    bit done = 0;
    do_reset();
    rdy_mode = 0; fir_delay = 3;
    push_pkt(2, 6, 16'h1111);
    start = cyc;
    for (int n = 0; n < 60; n++) begin
      step();
      if (cap.size() >= 6 && ret_cnt < 0 && !s_rcv) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL single_done: got timeout want completion"); end
    n_vec++; if (cap.size() != 6) begin n_err++; $display("FAIL single_beats: got %0d want 6", cap.size()); end
    if (cap.size() > 0) begin
      n_vec++; if (cap[0].cyc != start + 1) begin n_err++; $display("FAIL single_latency: got cycle %0d want %0d", cap[0].cyc, start + 1); end
    end
    for (int i = 0; i < cap.size() && i < 6; i++) begin
      n_vec++;
      if (cap[i].d !== 16'h1111 + 16'(i) || cap[i].ch != 2 || cap[i].sop !== (i == 0) || cap[i].eop !== (i == 5)) begin
        n_err++; $display("FAIL single_beat%0d: got d=%h ch=%0d sop=%b eop=%b want d=%h ch=2", i, cap[i].d, cap[i].ch, cap[i].sop, cap[i].eop, 16'h1111 + 16'(i));
      end
    end
    n_vec++; if (s_ready !== 4'b0 || s_fv !== 1'b0) begin n_err++; $display("FAIL single_idle_after: got ready=%b fv=%b want 0000/0", s_ready, s_fv); end
  endtask

  task automatic test_round_robin();
    cap_t exp[$];
    int rem[NC];
    int last = NC - 1;
    int viol = 0;
    int owner;
    int pk[NC];
    bit done = 0;
    do_reset();
    rdy_mode = 0; fir_delay = 10;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NC; c++) push_pkt(c, 3, 16'hA000 + 16'(c * 256 + p * 16));
    for (int c = 0; c < NC; c++) begin rem[c] = 2; pk[c] = 0; end
    for (int n = 0; n < 2 * NC; n++) begin
      owner = -1;
      for (int k = 1; k <= NC && owner < 0; k++)
        if (rem[(last + k) % NC] > 0) owner = (last + k) % NC;
      rem[owner]--; last = owner;
      for (int b = 0; b < 3; b++) begin
        cap_t e;
        e.d = 16'hA000 + 16'(owner * 256 + pk[owner] * 16 + b);
        e.sop = (b == 0); e.eop = (b == 2); e.ch = owner; e.cyc = 0;
        exp.push_back(e);
      end
      pk[owner]++;
    end
    for (int n = 0; n < 600; n++) begin
      step();
      if (s_rcv && ((s_ready & ~(4'b0001 << s_rc)) != 4'b0)) viol++;
      if (cap.size() >= exp.size() && all_empty() && ret_cnt < 0 && !s_rcv) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL rr_done: got timeout want completion"); end
    n_vec++; if (cap.size() != exp.size()) begin n_err++; $display("FAIL rr_beats: got %0d want %0d", cap.size(), exp.size()); end
    for (int i = 0; i < cap.size() && i < exp.size(); i++) begin
      n_vec++;
      if (cap[i].d !== exp[i].d || cap[i].ch != exp[i].ch) begin
        n_err++; $display("FAIL rr_beat%0d: got d=%h ch=%0d want d=%h ch=%0d", i, cap[i].d, cap[i].ch, exp[i].d, exp[i].ch);
      end
    end
    n_vec++; if (viol != 0) begin n_err++; $display("FAIL rr_other_ready: got %0d cycles want 0", viol); end
  endtask

  task automatic test_backpressure();
    bit done = 0;
    do_reset();
    rdy_mode = 2; fir_delay = 2;
    push_pkt(1, 4, 16'h5500);
    for (int n = 0; n < 80; n++) begin
      step();
      if (s_fv) begin
        n_vec++;
        if (s_ready !== {2'b00, s_rdy, 1'b0}) begin n_err++; $display("FAIL bp_ready_mirror: got %b want %b", s_ready, {2'b00, s_rdy, 1'b0}); end
      end
      if (cap.size() >= 4 && ret_cnt < 0 && !s_rcv) begin done = 1; break; end
    end
    n_vec++; if (!done || cap.size() != 4) begin n_err++; $display("FAIL bp_beats: got %0d want 4", cap.size()); end
    for (int i = 0; i < cap.size() && i < 4; i++) begin
      n_vec++;
      if (cap[i].d !== 16'h5500 + 16'(i) || cap[i].ch != 1) begin n_err++; $display("FAIL bp_beat%0d: got d=%h ch=%0d want d=%h ch=1", i, cap[i].d, cap[i].ch, 16'h5500 + 16'(i)); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_stray();
    do_reset();
    rdy_mode = 0;
    for (int b = 0; b < 3; b++) chq[3].push_back(mk(16'h3300 + 16'(b), 1'b0, 1'b0));
    for (int n = 0; n < 3; n++) begin
      step();
      n_vec++;
      if (s_ready !== 4'b1000 || s_fv !== 1'b0) begin n_err++; $display("FAIL stray_ready%0d: got ready=%b fv=%b want 1000/0", n, s_ready, s_fv); end
    end
    step();
    n_vec++; if (s_stray !== 16'd3) begin n_err++; $display("FAIL stray_count: got %0d want 3", s_stray); end
    n_vec++; if (cap.size() != 0) begin n_err++; $display("FAIL stray_forwarded: got %0d beats want 0", cap.size()); end
  endtask

  task automatic test_timeout();
    int c_eop = -1;
    bit done = 0;
    do_reset();
    rdy_mode = 0; fir_delay = -1;
    push_pkt(1, 2, 16'h7100);
    for (int n = 0; n < 50; n++) begin
      step();
      if (cap.size() >= 2) begin c_eop = cap[1].cyc; break; end
    end
    push_pkt(1, 2, 16'h7110);
    push_pkt(0, 2, 16'h7000);
    fir_delay = 2;
    for (int n = 0; n < 200; n++) begin
      step();
      if (to_pulses > 0 && cap.size() >= 6 && all_empty() && ret_cnt < 0 && !s_rcv) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL to_done: got timeout want completion"); end
    n_vec++; if (to_pulses != 1) begin n_err++; $display("FAIL to_pulse_count: got %0d want 1", to_pulses); end
    n_vec++; if (to_cyc != c_eop + 17) begin n_err++; $display("FAIL to_pulse_cycle: got %0d want %0d", to_cyc, c_eop + 17); end
    if (cap.size() >= 6) begin
      n_vec++; if (cap[2].ch != 0 || cap[2].d !== 16'h7000) begin n_err++; $display("FAIL to_next_grant: got ch=%0d d=%h want ch=0 d=7000", cap[2].ch, cap[2].d); end
      n_vec++; if (cap[4].ch != 1 || cap[4].d !== 16'h7110) begin n_err++; $display("FAIL to_later_grant: got ch=%0d d=%h want ch=1 d=7110", cap[4].ch, cap[4].d); end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit done = 0;
    do_reset();
    rdy_mode = 0; fir_delay = 1;
    chq[3].push_back(mk(16'h3A00, 1'b0, 1'b0));
    chq[3].push_back(mk(16'h3A01, 1'b0, 1'b0));
    push_pkt(0, 2, 16'h0A00);
    push_pkt(1, 4, 16'h1A00);
    for (int n = 0; n < 100; n++) begin
      step();
      if (cap.size() >= 3) break;
    end
    n_vec++; if (cap.size() != 3 || cap[2].ch != 1 || s_stray !== 16'd2) begin n_err++; $display("FAIL rst_setup: got beats=%0d stray=%0d want 3/2", cap.size(), s_stray); end
    @(negedge clk);
    ch_valid = 4'b0010; ch_startofpacket = '0; ch_endofpacket = '0; ch_data = '0;
    ch_data[1*DW +: DW] = 16'h1A01; fir_in_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (ch_ready !== 4'b0 || fir_in_valid !== 1'b0 || fir_in_data !== 16'h0) begin n_err++; $display("FAIL rst_async_fwd: got ready=%b fv=%b d=%h want 0", ch_ready, fir_in_valid, fir_in_data); end
    n_vec++; if ({result_channel_valid, result_channel, timeout_err} !== 4'b0) begin n_err++; $display("FAIL rst_async_result: got %b want 0000", {result_channel_valid, result_channel, timeout_err}); end
    n_vec++; if (stray_count !== 16'h0) begin n_err++; $display("FAIL rst_async_stray: got %0d want 0", stray_count); end
    clear_inputs();
    for (int i = 0; i < NC; i++) chq[i].delete();
    ret_cnt = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cap.delete();
    push_pkt(2, 2, 16'h2B00);
    push_pkt(1, 2, 16'h1B00);
    push_pkt(0, 2, 16'h0B00);
    for (int n = 0; n < 100; n++) begin
      step();
      if (cap.size() >= 6 && ret_cnt < 0 && !s_rcv) begin done = 1; break; end
    end
    n_vec++; if (!done || cap.size() != 6) begin n_err++; $display("FAIL rst_resume: got %0d beats want 6", cap.size()); end
    else begin
      n_vec++; if (cap[0].ch != 0 || cap[2].ch != 1 || cap[4].ch != 2) begin n_err++; $display("FAIL rst_order: got %0d,%0d,%0d want 0,1,2", cap[0].ch, cap[2].ch, cap[4].ch); end
    end
  endtask

  task automatic test_random(int iter);
    int stray_total = 0;
    int total = 0;
    int contig = 0;
    bit done = 0;
    do_reset();
    for (int i = 0; i < NC; i++) expq[i].delete();
    rdy_mode = 1; rand_valid = 1; rand_delay = 1;
    for (int c = 0; c < NC; c++) begin
      int npk = $urandom_range(1, 3);
      for (int p = 0; p < npk; p++) begin
        int len = $urandom_range(1, 5);
        if ($urandom % 3 == 0) begin
          chq[c].push_back(mk({2'(c), 14'h3FFF}, 1'b0, 1'b0));
          stray_total++;
        end
        for (int b = 0; b < len; b++) begin
          beat_t bt = mk({2'(c), 14'($urandom)}, b == 0, b == len - 1);
          chq[c].push_back(bt);
          expq[c].push_back(bt);
          total++;
        end
      end
    end
    for (int n = 0; n < 5000; n++) begin
      step();
      if (all_empty() && ret_cnt < 0 && !s_rcv) begin done = 1; break; end
    end
    step();
    n_vec++; if (!done || cap.size() != total) begin n_err++; $display("FAIL rand%0d_beats: got %0d want %0d", iter, cap.size(), total); end
    for (int i = 0; i < cap.size(); i++) begin
      beat_t e;
      if (i > 0 && !cap[i-1].eop && cap[i].ch != cap[i-1].ch) contig++;
      n_vec++;
      if (expq[cap[i].ch].size() == 0) begin
        n_err++; $display("FAIL rand%0d_extra: got d=%h ch=%0d want none", iter, cap[i].d, cap[i].ch);
      end else begin
        e = expq[cap[i].ch].pop_front();
        if (cap[i].d !== e.d || cap[i].sop !== e.sop || cap[i].eop !== e.eop) begin
          n_err++; $display("FAIL rand%0d_beat%0d: got d=%h sop=%b eop=%b want d=%h sop=%b eop=%b", iter, i, cap[i].d, cap[i].sop, cap[i].eop, e.d, e.sop, e.eop);
        end
      end
    end
    n_vec++; if (contig != 0) begin n_err++; $display("FAIL rand%0d_interleave: got %0d want 0", iter, contig); end
    n_vec++; if (s_stray !== 16'(stray_total)) begin n_err++; $display("FAIL rand%0d_stray: got %0d want %0d", iter, s_stray, stray_total); end
    n_vec++; if (to_pulses != 0) begin n_err++; $display("FAIL rand%0d_timeout: got %0d want 0", iter, to_pulses); end
    rdy_mode = 0; rand_valid = 0; rand_delay = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stray();
    test_timeout();
    test_reset_mid_packet();
    for (int it = 0; it < 3; it++) test_random(it);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion want $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
